// File: rtl/ff_argmax.sv
// ff_argmax: classifier stage that follows feed_forward.
// Consumes num_classes IEEE-754 binary32 words, one per accepted beat, and
// reports the arrival index and bit-exact value of the largest one. Ordering
// is done purely on the bit patterns: no arithmetic and no normalisation.
// NaN inputs are flagged, they still count toward N, and they never win.
module ff_argmax #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  num_classes,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] max_value,
    output logic              nan_seen,
    output logic              empty
);

    // Result reported when every word of the inference was a NaN.
    localparam logic [DATA_W-1:0] CANON_QNAN = DATA_W'(32'h7FC0_0000);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  n_q;          // class count latched at start
    logic [IDX_W-1:0]  cnt_q;        // index of the next word to accept
    logic [DATA_W-1:0] best_q;       // running maximum
    logic [IDX_W-1:0]  best_idx_q;   // index of the running maximum
    logic              have_best_q;  // a non-NaN word has been seen
    logic              nan_q;
    logic              empty_q;

    logic accept;
    logic word_nan;
    logic take;
    logic last_word;

    // Exponent all ones with a non-zero mantissa.
    function automatic logic is_nan(input logic [DATA_W-1:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

    // +0 and -0 both have zero magnitude.
    function automatic logic is_zero(input logic [DATA_W-1:0] w);
        return (w[30:0] == 31'd0);
    endfunction

    // Strict "a > b" for two non-NaN binary32 words, done on the raw bits.
    // Sign-magnitude ordering: positives ascend with magnitude, negatives
    // descend with magnitude, and any positive beats any negative except
    // for the signed-zero pair, which compares equal.
    function automatic logic is_greater(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
        logic gt;
        gt = 1'b0;
        if (is_zero(a) && is_zero(b)) begin
            gt = 1'b0;
        end else begin
            case ({a[31], b[31]})
                2'b00:   gt = (a[30:0] > b[30:0]);
                2'b11:   gt = (a[30:0] < b[30:0]);
                2'b01:   gt = 1'b1;
                default: gt = 1'b0;
            endcase
        end
        return gt;
    endfunction

    // Qualify the incoming beat and decide whether it displaces the current best.
    always_comb begin
        accept    = (state_q == S_COLLECT) && data_valid;
        word_nan  = is_nan(data_in);
        take      = accept && !word_nan &&
                    (!have_best_q || is_greater(data_in, best_q));
        last_word = accept && (cnt_q == n_q - IDX_W'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the status outputs decoded from the state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_classes == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                busy = 1'b1;
                if (last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Inference bookkeeping: latch N on start, track the running maximum and
    // NaN flag while collecting. Results then hold until the next start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_q         <= '0;
            cnt_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            have_best_q <= 1'b0;
            nan_q       <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q         <= num_classes;
                        cnt_q       <= '0;
                        best_q      <= '0;
                        best_idx_q  <= '0;
                        have_best_q <= 1'b0;
                        nan_q       <= 1'b0;
                        empty_q     <= (num_classes == '0);
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        cnt_q <= cnt_q + IDX_W'(1);
                        if (word_nan) begin
                            nan_q <= 1'b1;
                        end
                        if (take) begin
                            best_q      <= data_in;
                            best_idx_q  <= cnt_q;
                            have_best_q <= 1'b1;
                        end else if (last_word && !have_best_q) begin
                            // Every word was a NaN: report the canonical quiet NaN.
                            best_q     <= CANON_QNAN;
                            best_idx_q <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign class_idx = best_idx_q;
    assign max_value = best_q;
    assign nan_seen  = nan_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_ff_argmax.sv
// Self-checking bench for ff_argmax. The stimulus process queues the
// hand-computed result of each inference. A monitor pops the queue on every
// done pulse and compares the result fields and the done timing.
module tb_ff_argmax;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  num_classes = '0;
    logic [31:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  class_idx;
    logic [31:0] max_value;
    logic        nan_seen;
    logic        empty;

    ff_argmax #(.DATA_W(32), .IDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_classes(num_classes),
        .data_in    (data_in),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done),
        .class_idx  (class_idx),
        .max_value  (max_value),
        .nan_seen   (nan_seen),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] val;
        logic        nan;
        logic        emp;
        logic [31:0] edge_no;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: compares every done pulse against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (edge_cnt > 3000) begin
                $display("FAIL watchdog: got edge %0d, expected finish before 3000", edge_cnt);
                $fatal(1, "watchdog expired");
            end
            if (done === 1'b1) begin
                n_done++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done at edge %0d, expected none", edge_cnt);
                end else begin
                    e = sb.pop_front();
                    check("done_latency", 32'(edge_cnt), e.edge_no);
                    check("class_idx",    32'(class_idx), 32'(e.idx));
                    check("max_value",    max_value, e.val);
                    check("nan_seen",     32'(nan_seen), 32'(e.nan));
                    check("empty",        32'(empty), 32'(e.emp));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_inf(input logic [3:0] n);
        start       = 1'b1;
        num_classes = n;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), (n != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic send(input logic [31:0] w);
        data_in    = w;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic gap();
        data_valid = 1'b0;
        tick();
    endtask

    // Queue the expected result; done must appear in the cycle after the
    // edge that just accepted the last word (or the zero-count start).
    task automatic push_exp(input logic [3:0] idx, input logic [31:0] val,
                            input logic nan, input logic emp);
        exp_t e;
        e.idx     = idx;
        e.val     = val;
        e.nan     = nan;
        e.emp     = emp;
        e.edge_no = 32'(edge_cnt);
        sb.push_back(e);
    endtask

    task automatic expect_done(input logic [3:0] idx, input logic [31:0] val,
                               input logic nan, input logic emp);
        push_exp(idx, val, nan, emp);
        data_valid = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_done"},      32'(done), 32'd0);
        check({tag, "_class_idx"}, 32'(class_idx), 32'd0);
        check({tag, "_max_value"}, max_value, 32'd0);
        check({tag, "_nan_seen"},  32'(nan_seen), 32'd0);
        check({tag, "_empty"},     32'(empty), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Mixed signs: 1.0, 2.0, -3.0, 0.5 -> 2.0 at index 1.
        start_inf(4'd4);
        send(32'h3F80_0000);
        send(32'h4000_0000);
        send(32'hC040_0000);
        send(32'h3F00_0000);
        expect_done(4'd1, 32'h4000_0000, 1'b0, 1'b0);

        // All negative: -3, -1, -2 -> -1 at index 1.
        start_inf(4'd3);
        send(32'hC040_0000);
        send(32'hBF80_0000);
        send(32'hC000_0000);
        expect_done(4'd1, 32'hBF80_0000, 1'b0, 1'b0);

        // Signed-zero tie: -0 then +0, the first one wins.
        start_inf(4'd2);
        send(32'h8000_0000);
        send(32'h0000_0000);
        expect_done(4'd0, 32'h8000_0000, 1'b0, 1'b0);

        // NaNs around a real value.
        start_inf(4'd3);
        send(32'h7FC0_0000);
        send(32'h3F00_0000);
        send(32'h7F80_0001);
        expect_done(4'd1, 32'h3F00_0000, 1'b1, 1'b0);

        // All NaN -> canonical quiet NaN at index 0.
        start_inf(4'd2);
        send(32'h7FC0_0000);
        send(32'h7FC0_0000);
        expect_done(4'd0, 32'h7FC0_0000, 1'b1, 1'b0);

        // Gapped valid 1,0,0,1,1,0,1,1 with a stray start in a gap.
        start_inf(4'd5);
        send(32'h3F80_0000);
        gap();
        start       = 1'b1;
        num_classes = 4'd1;
        gap();
        start = 1'b0;
        check("busy_ignores_start", 32'(busy), 32'd1);
        send(32'h4000_0000);
        send(32'h3F00_0000);
        gap();
        send(32'h4040_0000);
        send(32'h4120_0000);
        push_exp(4'd4, 32'h4120_0000, 1'b0, 1'b0);
        // Valid beats in DONE and IDLE must not be taken.
        data_in    = 32'h7F00_0000;
        data_valid = 1'b1;
        tick();
        tick();
        data_valid = 1'b0;
        check("idle_after_extra_beats", 32'(busy), 32'd0);
        check("result_held", max_value, 32'h4120_0000);

        // Zero classes, then a single negative infinity.
        start_inf(4'd0);
        expect_done(4'd0, 32'h0000_0000, 1'b0, 1'b1);
        start_inf(4'd1);
        send(32'hFF80_0000);
        expect_done(4'd0, 32'hFF80_0000, 1'b0, 1'b0);

        // Reset in the middle of an inference discards everything.
        start_inf(4'd4);
        send(32'h3F80_0000);
        send(32'h4100_0000);
        rst        = 1'b0;
        data_in    = 32'h4200_0000;
        data_valid = 1'b1;
        tick();
        rst        = 1'b1;
        data_valid = 1'b0;
        check_all_zero("mid_reset");
        tick();
        start_inf(4'd4);
        send(32'h3F80_0000);
        send(32'hBF80_0000);
        send(32'h4000_0000);
        send(32'h3F00_0000);
        expect_done(4'd2, 32'h4000_0000, 1'b0, 1'b0);

        repeat (5) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("done_pulse_count", 32'(n_done), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
